// File: rtl/cache_wt_pkg.sv
// Shared definitions for the write-through cache slice.
// Holds the default geometry, the default uncached (MMIO) address nibble,
// the FSM state encodings and a small address classification helper.
package cache_wt_pkg;

  localparam int          LINES_DEF  = 64;
  localparam logic [3:0]  UC_NIB_DEF = 4'hE;

  // FSM state encodings (2-bit, legacy-compatible constants)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;

  // An address is uncached when its top nibble equals the MMIO marker.
  function automatic logic is_uc(input logic [31:0] addr, input logic [3:0] nib);
    return addr[31:28] == nib;
  endfunction

endpackage

// File: rtl/cache_wt_mem.sv
// Tag + data storage for cache_wt: LINES x (TAGW+32) bits, one write port
// and one asynchronous read port (maps onto distributed RAM).
// Ports:
//   clk              clock
//   we/waddr         write enable and line index
//   wtag/wdata       tag and data word written at the rising edge
//   raddr            read line index (combinational read)
//   rtag/rdata       stored tag and data of line raddr
module cache_mem #(
  parameter int LINES = 64,
  parameter int TAGW  = 24
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(LINES)-1:0] waddr,
  input  logic [TAGW-1:0]          wtag,
  input  logic [31:0]              wdata,
  input  logic [$clog2(LINES)-1:0] raddr,
  output logic [TAGW-1:0]          rtag,
  output logic [31:0]              rdata
);

  logic [TAGW+31:0] mem_q [LINES];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= {wtag, wdata};
  end

  assign rtag  = mem_q[raddr][TAGW+31:32];
  assign rdata = mem_q[raddr][31:0];

endmodule

// File: rtl/cache_wt.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate cache.
// CPU side and memory side both use a pulse protocol: a request (rd or we)
// is a one-cycle pulse sampled in IDLE; ready is high when idle and in the
// completion cycle, low while a transaction is outstanding. A completion
// happens in the cycle m_ready=1 is seen (possibly the request cycle itself).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   a, d, we, rd        CPU address / write data / write and read pulses
//   spo, ready          CPU read data and completion
//   inv                 invalidate-all pulse
//   m_a, m_d, m_we, m_rd memory-side request
//   m_spo, m_ready      memory-side read data and completion
//   hit_cnt, miss_cnt   cached-read hit / miss counters
//   dbg_state           current FSM state (ST_* encodings)
module cache_wt
  import cache_wt_pkg::*;
#(
  parameter int         LINES  = LINES_DEF,
  parameter logic [3:0] UC_NIB = UC_NIB_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] d,
  input  logic        we,
  input  logic        rd,
  output logic [31:0] spo,
  output logic        ready,
  input  logic        inv,
  output logic [31:0] m_a,
  output logic [31:0] m_d,
  output logic        m_we,
  output logic        m_rd,
  input  logic [31:0] m_spo,
  input  logic        m_ready,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [1:0]  dbg_state
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 30 - IDXW;

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [31:0]      hit_cnt_q, hit_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;

  logic [IDXW-1:0]  req_idx, wait_idx, mem_waddr;
  logic [TAGW-1:0]  req_tag, wait_tag, line_tag, mem_wtag;
  logic [31:0]      line_data, mem_wdata;
  logic             mem_we, req_uc, req_hit;
  logic             unused_addr_bits;

  assign req_idx  = a[IDXW+1:2];
  assign req_tag  = a[31:IDXW+2];
  assign wait_idx = addr_q[IDXW+1:2];
  assign wait_tag = addr_q[31:IDXW+2];
  assign req_uc   = is_uc(a, UC_NIB);
  assign req_hit  = valid_q[req_idx] && (line_tag == req_tag) && !req_uc;
  assign unused_addr_bits = ^a[1:0];

  cache_mem #(.LINES(LINES), .TAGW(TAGW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wtag  (mem_wtag),
    .wdata (mem_wdata),
    .raddr (req_idx),
    .rtag  (line_tag),
    .rdata (line_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    ready      = 1'b1;
    spo        = 32'h0;
    m_a        = addr_q;
    m_d        = data_q;
    m_we       = 1'b0;
    m_rd       = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = req_idx;
    mem_wtag   = req_tag;
    mem_wdata  = d;

    case (state_q)
      ST_IDLE: begin
        if (we) begin
          // Write-through; only an existing line is updated (no allocate).
          m_we = 1'b1;
          m_a  = a;
          m_d  = d;
          mem_we = req_hit;
          if (!m_ready) begin
            ready   = 1'b0;
            state_d = ST_WR_WAIT;
            addr_d  = a;
            data_d  = d;
          end
        end else if (rd) begin
          if (req_hit) begin
            spo       = line_data;
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            m_rd = 1'b1;
            m_a  = a;
            if (!req_uc) miss_cnt_d = miss_cnt_q + 32'd1;
            if (m_ready) begin
              spo = m_spo;
              if (!req_uc) begin
                mem_we           = 1'b1;
                mem_wdata        = m_spo;
                valid_d[req_idx] = 1'b1;
              end
            end else begin
              ready   = 1'b0;
              state_d = ST_RD_WAIT;
              addr_d  = a;
            end
          end
        end
      end
      ST_RD_WAIT: begin
        ready = 1'b0;
        if (m_ready) begin
          ready   = 1'b1;
          spo     = m_spo;
          state_d = ST_IDLE;
          if (!is_uc(addr_q, UC_NIB)) begin
            mem_we            = 1'b1;
            mem_waddr         = wait_idx;
            mem_wtag          = wait_tag;
            mem_wdata         = m_spo;
            valid_d[wait_idx] = 1'b1;
          end
        end
      end
      ST_WR_WAIT: begin
        ready = 1'b0;
        if (m_ready) begin
          ready   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Invalidate overrides any fill landing in the same cycle.
    if (inv) valid_d = '0;

    // Reset abandons any outstanding transaction: no fill, no request.
    if (rst) begin
      state_d    = ST_IDLE;
      addr_d     = 32'h0;
      data_d     = 32'h0;
      valid_d    = '0;
      hit_cnt_d  = 32'h0;
      miss_cnt_d = 32'h0;
      ready      = 1'b1;
      m_we       = 1'b0;
      m_rd       = 1'b0;
      mem_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    addr_q     <= addr_d;
    data_q     <= data_d;
    valid_q    <= valid_d;
    hit_cnt_q  <= hit_cnt_d;
    miss_cnt_q <= miss_cnt_d;
  end

  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign dbg_state = state_q;

endmodule
